dmem_access: RTL

Sequential data-memory access controller for the memory stage. Accepts one load/store request at a time from the pipeline, checks alignment, and drives a single-beat data-memory port. Loaded words pass through the existing `lu` for extraction and sign/zero extension. Sub-word stores go through the existing `su` merge, done as read-modify-write unless byte strobes are compiled in.

---
 rtl/dmem_access_pkg.sv | 46 ++++
 rtl/dmem_misalign.sv | 31 +++
 rtl/lu.sv | 42 ++++
 rtl/su.sv | 36 +++
 rtl/dmem_access.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_access_pkg.sv
// dmem_access_pkg
//   Shared definitions for the data-memory access controller: RISC-V
//   load/store funct3 encodings, controller state encoding and the byte
//   enable helper used by the store merge and the strobe path.
package dmem_access_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_RD   = 2'd1,
    DMEM_WR   = 2'd2,
    DMEM_RESP = 2'd3
  } dmem_state_e;

  // A store that covers the whole bus word needs no merge and no read.
  function automatic logic is_full_store(input logic [2:0] f3, input int xlen);
    return (xlen == 32) ? (f3 == F3_SW) : (f3 == F3_SD);
  endfunction

  // Byte enables of a store inside a 64-bit word; narrower buses truncate.
  function automatic logic [7:0] store_be(input logic [2:0] off, input logic [2:0] f3);
    logic [7:0] base;
    case (f3)
      F3_SB:   base = 8'h01;
      F3_SH:   base = 8'h03;
      F3_SW:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/dmem_misalign.sv
// dmem_misalign
//   Combinational alignment/legality check for a load/store funct3 at a
//   byte offset. Shared with the fetch/trap logic.
//   Ports:
//     addr_i   [2:0]  low byte-address bits
//     funct3_i [2:0]  load/store funct3 (load encoding space)
//     err_o           1 = misaligned or illegal for this XLEN
module dmem_misalign
  import dmem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0] addr_i,
  input  logic [2:0] funct3_i,
  output logic       err_o
);

  always_comb begin
    err_o = 1'b0;
    case (funct3_i)
      F3_LB, F3_LBU: err_o = 1'b0;
      F3_LH, F3_LHU: err_o = addr_i[0];
      F3_LW:         err_o = |addr_i[1:0];
      // Doubleword and zero-extended word loads only exist on RV64.
      F3_LWU:        err_o = (XLEN == 32) || (|addr_i[1:0]);
      F3_LD:         err_o = (XLEN == 32) || (|addr_i[2:0]);
      default:       err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/lu.sv
// lu
//   Load unit: extracts the addressed byte/half/word/double from a bus
//   word and sign- or zero-extends it according to funct3.
//   Ports:
//     rdata_i  [XLEN-1:0]       full bus word from memory
//     off_i    [log2(XLEN/8)-1:0] byte offset inside the word
//     funct3_i [2:0]            load funct3
//     data_o   [XLEN-1:0]       extended result
module lu
  import dmem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]             rdata_i,
  input  logic [$clog2(XLEN/8)-1:0]   off_i,
  input  logic [2:0]                  funct3_i,
  output logic [XLEN-1:0]             data_o
);

  logic [XLEN-1:0]    sh;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;
  logic signed [31:0] w_s;

  always_comb begin
    sh  = rdata_i >> {off_i, 3'b000};
    b_s = sh[7:0];
    h_s = sh[15:0];
    w_s = sh[31:0];
    case (funct3_i)
      F3_LB:   data_o = XLEN'(b_s);
      F3_LH:   data_o = XLEN'(h_s);
      F3_LW:   data_o = XLEN'(w_s);
      F3_LD:   data_o = sh;
      F3_LBU:  data_o = XLEN'(sh[7:0]);
      F3_LHU:  data_o = XLEN'(sh[15:0]);
      F3_LWU:  data_o = XLEN'(sh[31:0]);
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/su.sv
// su
//   Store unit: merges right-aligned store data into an existing bus word
//   at the addressed bytes. Bytes outside the store keep data_l_i.
//   Ports:
//     off_i    [log2(XLEN/8)-1:0] byte offset inside the word
//     funct3_i [2:0]            store funct3
//     data_l_i [XLEN-1:0]       word the store is merged into
//     wdata_i  [XLEN-1:0]       right-aligned store data
//     data_o   [XLEN-1:0]       merged word
module su
  import dmem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  logic [2:0]                funct3_i,
  input  logic [XLEN-1:0]           data_l_i,
  input  logic [XLEN-1:0]           wdata_i,
  output logic [XLEN-1:0]           data_o
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0]   be;
  logic [XLEN-1:0] wsh;

  always_comb begin
    be     = NB'(store_be(3'(off_i), funct3_i));
    wsh    = wdata_i << {off_i, 3'b000};
    data_o = data_l_i;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) data_o[8*i +: 8] = wsh[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_access.sv
// dmem_access
//   Memory-stage data-memory access controller. Takes one load/store at a
//   time, rejects misaligned/illegal accesses without touching memory, and
//   drives a single-beat memory port. Loads pass through lu; sub-word
//   stores are merged by su, as read-modify-write in the default build.
//   Build option: define DMEM_WSTRB_EN to issue sub-word stores directly
//   with byte strobes (no read beat).
//   Ports:
//     clk, rst                         clock, async active-high reset
//     req_valid/req_ready              request handshake
//     req_store, req_funct3,
//     req_addr, req_wdata              request payload, captured on accept
//     mem_req, mem_we, mem_addr,
//     mem_wdata, mem_wstrb             registered memory command
//     mem_rdata, mem_ack               memory response
//     resp_valid/resp_ready            result handshake
//     resp_data, resp_err              extended load data / misalign flag
module dmem_access
  import dmem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  dmem_state_e       state_q;
  logic              req_ready_q;
  logic [OFFW-1:0]   off_q;
  logic [2:0]        funct3_q;
  logic              store_q;
`ifndef DMEM_WSTRB_EN
  logic [XLEN-1:0]   wdata_q;
`endif
  logic              mem_req_q;
  logic              mem_we_q;
  logic [XLEN-1:0]   mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [NB-1:0]     mem_wstrb_q;
  logic              resp_valid_q;
  logic [XLEN-1:0]   resp_data_q;
  logic              resp_err_q;

  logic              accept_d;
  logic              mis_err_d;
  logic              req_err_d;
  logic [XLEN-1:0]   addr_algn_d;
  logic [XLEN-1:0]   lu_data_d;
  logic [XLEN-1:0]   su_data_d;

  assign accept_d    = req_valid && req_ready_q;
  // Stores have no funct3 with bit 2 set; treat those as illegal too.
  assign req_err_d   = mis_err_d || (req_store && req_funct3[2]);
  assign addr_algn_d = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

  dmem_misalign #(.XLEN(XLEN)) u_misalign (
    .addr_i   (req_addr[2:0]),
    .funct3_i (req_funct3),
    .err_o    (mis_err_d)
  );

  lu #(.XLEN(XLEN)) u_lu (
    .rdata_i  (mem_rdata),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (lu_data_d)
  );

  // With strobes the merge happens at accept time against zero, so su sees
  // the live request; otherwise it merges the captured store into the
  // word returned by the read beat.
  su #(.XLEN(XLEN)) u_su (
`ifdef DMEM_WSTRB_EN
    .off_i    (req_addr[OFFW-1:0]),
    .funct3_i (req_funct3),
    .data_l_i ({XLEN{1'b0}}),
    .wdata_i  (req_wdata),
`else
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_l_i (mem_rdata),
    .wdata_i  (wdata_q),
`endif
    .data_o   (su_data_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= DMEM_IDLE;
      req_ready_q  <= 1'b1;
      off_q        <= '0;
      funct3_q     <= '0;
      store_q      <= 1'b0;
`ifndef DMEM_WSTRB_EN
      wdata_q      <= '0;
`endif
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        DMEM_IDLE: begin
          if (accept_d) begin
            req_ready_q <= 1'b0;
            off_q       <= req_addr[OFFW-1:0];
            funct3_q    <= req_funct3;
            store_q     <= req_store;
`ifndef DMEM_WSTRB_EN
            wdata_q     <= req_wdata;
`endif
            if (req_err_d) begin
              state_q      <= DMEM_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_data_q  <= '0;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= addr_algn_d;
              if (!req_store) begin
                state_q     <= DMEM_RD;
                mem_we_q    <= 1'b0;
                mem_wdata_q <= '0;
                mem_wstrb_q <= '0;
              end else if (is_full_store(req_funct3, XLEN)) begin
                state_q     <= DMEM_WR;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= req_wdata;
                mem_wstrb_q <= '1;
              end else begin
`ifdef DMEM_WSTRB_EN
                state_q     <= DMEM_WR;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= su_data_d;
                mem_wstrb_q <= NB'(store_be(3'(req_addr[OFFW-1:0]), req_funct3));
`else
                // Read beat first; the merged word is written from WR.
                state_q     <= DMEM_RD;
                mem_we_q    <= 1'b0;
                mem_wdata_q <= '0;
                mem_wstrb_q <= '0;
`endif
              end
            end
          end
        end
        DMEM_RD: begin
          if (mem_ack) begin
            if (store_q) begin
              // mem_req stays high: the write beat follows directly.
              state_q     <= DMEM_WR;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= su_data_d;
              mem_wstrb_q <= '1;
            end else begin
              state_q      <= DMEM_RESP;
              mem_req_q    <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_data_q  <= lu_data_d;
              resp_err_q   <= 1'b0;
            end
          end
        end
        DMEM_WR: begin
          if (mem_ack) begin
            state_q      <= DMEM_RESP;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wstrb_q  <= '0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        DMEM_RESP: begin
          if (resp_ready) begin
            state_q      <= DMEM_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state_q <= DMEM_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule
